// File: rtl/clock_gating_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the multi-channel clock gater: channel state encoding and default sizing.
package clock_gating_pkg;

  typedef enum logic [1:0] {
    GATED     = 2'b00,
    ACTIVE    = 2'b01,
    COUNTDOWN = 2'b10
  } cg_state_t;

  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/clock_gate_cell.sv
`timescale 1ns/1ps
// Glitch-free clock gate: enable captured by a latch open while clk is low, ANDed with clk.
// Reset clears the latch asynchronously, so an in-flight high phase is cut short immediately.
module clock_gate_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_gclk
);

  logic r_en_lat;

  always_latch begin
    if (!reset_n) begin
      r_en_lat <= 1'b0;
    end else if (!clk) begin
      r_en_lat <= i_en;
    end
  end

  assign o_gclk = clk & r_en_lat;

endmodule

// File: rtl/multi_channel_clock_gating.sv
`timescale 1ns/1ps
// Per-channel activity-driven clock gating with idle hysteresis; clk_en/wake are registered,
// gated_clk follows clk_en by one cycle. No flow control: inputs are sampled every posedge.
module multi_channel_clock_gating
  import clock_gating_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  activity,
  input  logic [N_CH-1:0]  force_on,
  input  logic [CNT_W-1:0] idle_limit,
  output logic [N_CH-1:0]  gated_clk,
  output logic [N_CH-1:0]  clk_en,
  output logic [N_CH-1:0]  wake
);

  localparam logic [CNT_W-1:0] LIM_ONE = CNT_W'(1);

  // idle_limit of 0 or 1 both gate on the first low sample
  logic w_lim_le1;
  assign w_lim_le1 = (idle_limit <= LIM_ONE);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cg_state_t        r_state;
    cg_state_t        w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W:0]   w_inc;
    logic             r_en;
    logic             r_wake;
    logic             w_nxt_wake;
    logic             w_dem;

    assign w_dem = activity[g] | force_on[g];
    // One extra bit so the increment can never wrap, even if idle_limit shrank mid-countdown
    assign w_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_wake  = 1'b0;
      case (r_state)
        GATED: begin
          if (w_dem) begin
            w_nxt_state = ACTIVE;
            w_nxt_cnt   = '0;
            w_nxt_wake  = 1'b1;
          end
        end
        ACTIVE: begin
          w_nxt_cnt = '0;
          if (!w_dem) begin
            if (w_lim_le1) begin
              w_nxt_state = GATED;
            end else begin
              w_nxt_state = COUNTDOWN;
              w_nxt_cnt   = LIM_ONE;
            end
          end
        end
        COUNTDOWN: begin
          if (w_dem) begin
            w_nxt_state = ACTIVE;
            w_nxt_cnt   = '0;
          end else if (w_inc >= {1'b0, idle_limit}) begin
            w_nxt_state = GATED;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = w_inc[CNT_W-1:0];
          end
        end
        default: begin
          w_nxt_state = GATED;
          w_nxt_cnt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= GATED;
        r_cnt   <= '0;
        r_en    <= 1'b0;
        r_wake  <= 1'b0;
      end else begin
        r_state <= w_nxt_state;
        r_cnt   <= w_nxt_cnt;
        r_en    <= (w_nxt_state != GATED);
        r_wake  <= w_nxt_wake;
      end
    end

    assign clk_en[g] = r_en;
    assign wake[g]   = r_wake;

    clock_gate_cell u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (r_en),
      .o_gclk  (gated_clk[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_gating.sv
`timescale 1ns/1ps
// Randomized and directed bench for multi_channel_clock_gating against a run-length model.
module tb_multi_channel_clock_gating;

  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] activity = 4'hF;
  logic [3:0] force_on = 4'hF;
  logic [7:0] idle_limit = 8'd3;
  logic [3:0] gated_clk;
  logic [3:0] clk_en;
  logic [3:0] wake;

  int total = 0;
  int bad = 0;
  int glitches = 0;

  // Model: enabled flag, wake pulse, expected gated high phase, and current low-sample run length
  logic [3:0] m_en = '0;
  logic [3:0] m_wake = '0;
  logic [3:0] m_gate = '0;
  int         m_run [NC];
  logic [3:0] last_hi = '0;

  real        rise_t [NC];
  logic [3:0] gprev = '0;

  multi_channel_clock_gating #(.N_CH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .activity   (activity),
    .force_on   (force_on),
    .idle_limit (idle_limit),
    .gated_clk  (gated_clk),
    .clk_en     (clk_en),
    .wake       (wake)
  );

  always #5 clk = ~clk;

  // Any high pulse narrower than the clk high phase is a glitch unless reset truncated it
  always @(gated_clk or reset_n) begin
    for (int c = 0; c < NC; c++) begin
      if (gated_clk[c] && !gprev[c]) begin
        rise_t[c] = $realtime;
      end else if (!gated_clk[c] && gprev[c]) begin
        if (($realtime - rise_t[c] < 4.9) && reset_n) glitches++;
      end
    end
    gprev = gated_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '0;
    m_wake = '0;
    m_gate = '0;
    for (int c = 0; c < NC; c++) m_run[c] = 0;
  endtask

  // Called just after a negedge: drive inputs, advance the model on the posedge, check both phases
  task automatic tick(input logic [3:0] a, input logic [3:0] f);
    activity = a;
    force_on = f;
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      int lim;
      lim = (idle_limit == 8'd0) ? 1 : int'(idle_limit);
      m_gate[c] = m_en[c];
      if (a[c] | f[c]) begin
        m_wake[c] = !m_en[c];
        m_en[c]   = 1'b1;
        m_run[c]  = 0;
      end else begin
        m_wake[c] = 1'b0;
        if (m_en[c]) begin
          m_run[c]++;
          if (m_run[c] >= lim) begin
            m_en[c]  = 1'b0;
            m_run[c] = 0;
          end
        end
      end
    end
    #1;
    last_hi = gated_clk;
    chk("clk_en", clk_en, m_en);
    chk("wake", wake, m_wake);
    chk("gclk_high_phase", gated_clk, m_gate);
    @(negedge clk);
    #1;
    chk("gclk_low_phase", gated_clk, 0);
  endtask

  initial begin
    int hi3;
    logic [3:0] ra;
    logic [3:0] rf;
    model_reset();

    // Reset held with every demand asserted
    #21;
    chk("rst_gclk", gated_clk, 4'h0);
    chk("rst_clk_en", clk_en, 4'h0);
    chk("rst_wake", wake, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tick(4'h0, 4'h0);
    tick(4'h0, 4'h0);

    // Channel 0 wakes on activity
    idle_limit = 8'd3;
    tick(4'h1, 4'h0);
    chk("wake0_en", clk_en[0], 1);
    chk("wake0_pulse", wake[0], 1);
    chk("wake0_no_hi_yet", last_hi[0], 0);
    chk("model_wake0", m_wake[0], 1);
    tick(4'h1, 4'h0);
    chk("wake0_pulse_gone", wake[0], 0);
    chk("wake0_first_hi", last_hi[0], 1);

    // Channel 1 hysteresis: two lows then activity keeps it alive, three lows gate it
    tick(4'h2, 4'h0);
    tick(4'h0, 4'h0);
    tick(4'h0, 4'h0);
    tick(4'h2, 4'h0);
    chk("hyst1_kept", clk_en[1], 1);
    tick(4'h0, 4'h0);
    tick(4'h0, 4'h0);
    chk("hyst1_still_on", clk_en[1], 1);
    tick(4'h0, 4'h0);
    chk("hyst1_gated", clk_en[1], 0);
    chk("model_hyst1", m_en[1], 0);
    tick(4'h0, 4'h0);
    chk("hyst1_no_pulse", last_hi[1], 0);

    // idle_limit 0 gates on the first low sample
    idle_limit = 8'd0;
    tick(4'h4, 4'h0);
    tick(4'h0, 4'h0);
    chk("lim0_gated", clk_en[2], 0);

    // Channel 3 forced on, then released
    idle_limit = 8'd3;
    hi3 = 0;
    for (int i = 0; i < 20; i++) begin
      tick(4'h0, 4'h8);
      if (last_hi[3]) hi3++;
    end
    chk("force3_hi_count", hi3, 19);
    tick(4'h0, 4'h0);
    tick(4'h0, 4'h0);
    chk("force3_release_on", clk_en[3], 1);
    tick(4'h0, 4'h0);
    chk("force3_release_off", clk_en[3], 0);

    // Randomized traffic with occasional idle_limit changes, including mid-countdown shrinks
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) idle_limit = 8'($urandom_range(0, 5));
      for (int c = 0; c < NC; c++) begin
        ra[c] = ($urandom_range(0, 9) < 3);
        rf[c] = ($urandom_range(0, 19) == 0);
      end
      tick(ra, rf);
    end

    // Reset during a high phase with every channel running
    tick(4'hF, 4'h0);
    tick(4'hF, 4'h0);
    @(posedge clk);
    #2;
    chk("pre_rst_gclk", gated_clk, 4'hF);
    reset_n = 1'b0;
    #0.5;
    chk("mid_rst_gclk", gated_clk, 4'h0);
    chk("mid_rst_clk_en", clk_en, 4'h0);
    chk("mid_rst_wake", wake, 4'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("held_rst_gclk", gated_clk, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tick(4'h0, 4'h0);
    tick(4'h0, 4'h0);
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < NC; c++) begin
        ra[c] = ($urandom_range(0, 9) < 4);
        rf[c] = ($urandom_range(0, 29) == 0);
      end
      tick(ra, rf);
    end

    chk("glitch_count", glitches, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
